mux_rr_pipe: RTL and testbench

MUX_RR_PIPE -- requirements
Module: mux_rr_pipe

---
 rtl/mux_rr_pipe.sv | 72 +++++++
 tb/tb_mux_rr_pipe.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: registered NCH:1 mux, SEL or round-robin grant, valid/ready both sides; ports CLK RST IN_DATA IN_VALID IN_READY MODE SEL OUT_DATA OUT_VALID OUT_READY OUT_CH; MUX_RR_PIPE_CNT_EN adds XFER_CNT
module mux_rr_pipe #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH*WIDTH-1:0] IN_DATA,
  input  logic [NCH-1:0]       IN_VALID,
  output logic [NCH-1:0]       IN_READY,
  input  logic                 MODE,
  input  logic [SELW-1:0]      SEL,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [SELW-1:0]      OUT_CH
`ifdef MUX_RR_PIPE_CNT_EN
  ,
  output logic [15:0]          XFER_CNT
`endif
);
  logic [SELW-1:0]  ptr_q, ptr_d, out_ch_q, gnt;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q, gnt_v, load;
  always_comb begin
    gnt   = '0;
    gnt_v = 1'b0;
    if (!MODE) begin
      gnt   = SEL;
      gnt_v = (int'(SEL) < NCH) && IN_VALID[SEL];
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (IN_VALID[(int'(ptr_q) + i) % NCH]) begin
          gnt   = SELW'((int'(ptr_q) + i) % NCH);
          gnt_v = 1'b1;
        end
      end
    end
  end
  assign load     = gnt_v & (~out_valid_q | OUT_READY) & ~RST;
  assign IN_READY = load ? ({{(NCH-1){1'b0}}, 1'b1} << gnt) : '0;
  assign ptr_d    = (load && MODE) ? ((int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1) : ptr_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= IN_DATA[int'(gnt)*WIDTH +: WIDTH];
        out_ch_q    <= gnt;
      end else if (OUT_READY) begin
        out_valid_q <= 1'b0;
      end
      ptr_q <= ptr_d;
    end
  end
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_CH    = out_ch_q;
`ifdef MUX_RR_PIPE_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else if (out_valid_q && OUT_READY) cnt_q <= cnt_q + 16'd1;
  end
  assign XFER_CNT = cnt_q;
`endif
endmodule

// File: tb/tb_mux_rr_pipe.sv
// tb_mux_rr_pipe: directed stimulus with expected words queued at issue and checked by an output monitor
module tb_mux_rr_pipe;
  logic         CLK = 1'b0;
  logic         RST;
  logic [127:0] IN_DATA;
  logic [3:0]   IN_VALID, IN_READY;
  logic         MODE;
  logic [1:0]   SEL, OUT_CH;
  logic [31:0]  OUT_DATA;
  logic         OUT_VALID, OUT_READY;
`ifdef MUX_RR_PIPE_CNT_EN
  logic [15:0]  XFER_CNT;
  logic [15:0]  tb_cnt = '0;
`endif
  int           checks = 0;
  int           fails = 0;
  int           stepn = 0;
  bit           beef = 1'b0;
  logic [33:0]  q[$];
  logic [33:0]  exp_w;
  logic [31:0]  saved;
  mux_rr_pipe dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .MODE(MODE), .SEL(SEL), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_CH(OUT_CH)
`ifdef MUX_RR_PIPE_CNT_EN
    , .XFER_CNT(XFER_CNT)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r, input int e);
    logic [3:0] er;
    @(posedge CLK);
    #1;
    stepn++;
    for (int k = 0; k < 4; k++)
      IN_DATA[k*32 +: 32] = (beef && k == 2) ? 32'hDEADBEEF : {8'hC0 + 8'(k), 8'h00, 16'(stepn)};
    MODE = m;
    SEL = s;
    IN_VALID = v;
    OUT_READY = r;
    #2;
    er = (e < 0) ? 4'h0 : 4'(1 << e);
    chk($sformatf("in_ready_step%0d", stepn), 32'(IN_READY), 32'(er));
    if (e >= 0) q.push_back({2'(e), IN_DATA[e*32 +: 32]});
  endtask
  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
      checks++;
`ifdef MUX_RR_PIPE_CNT_EN
      tb_cnt <= tb_cnt + 16'd1;
`endif
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got ch %0d data %0h, expected no word", OUT_CH, OUT_DATA);
      end else begin
        exp_w = q.pop_front();
        if ({OUT_CH, OUT_DATA} !== exp_w) begin
          fails++;
          $display("FAIL out_word: got ch %0d data %0h, expected ch %0d data %0h",
                   OUT_CH, OUT_DATA, exp_w[33:32], exp_w[31:0]);
        end
      end
    end
  end
  initial begin
    RST = 1'b1; MODE = 1'b1; SEL = '0; IN_VALID = 4'hF; OUT_READY = 1'b1; IN_DATA = '1;
    repeat (2) begin
      @(posedge CLK);
      #3;
      chk("rst_in_ready", 32'(IN_READY), 32'h0);
    end
    chk("rst_out_valid", 32'(OUT_VALID), 32'h0);
    chk("rst_out_data", OUT_DATA, 32'h0);
    chk("rst_out_ch", 32'(OUT_CH), 32'h0);
    IN_VALID = 4'h0;
    RST = 1'b0;
    beef = 1'b1;
    step(0, 2, 4'b0100, 1, 2);
    beef = 1'b0;
    step(0, 2, 4'b0000, 1, -1);
    chk("sel_out_data", OUT_DATA, 32'hDEADBEEF);
    chk("sel_out_ch", 32'(OUT_CH), 32'd2);
    chk("sel_out_valid", 32'(OUT_VALID), 32'd1);
    step(0, 2, 4'b1011, 1, -1);
    step(0, 0, 4'b0001, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 4'hF, 1, i % 4);
    step(0, 3, 4'hF, 1, 3);
    step(1, 0, 4'hF, 1, 0);
    step(1, 0, 4'b0010, 1, 1);
    saved = IN_DATA[63:32];
    repeat (3) begin
      step(1, 0, 4'hF, 0, -1);
      chk("stall_out_ch", 32'(OUT_CH), 32'd1);
      chk("stall_out_data", OUT_DATA, saved);
      chk("stall_out_valid", 32'(OUT_VALID), 32'd1);
    end
    step(1, 0, 4'hF, 1, 2);
    step(1, 0, 4'h0, 1, -1);
    step(1, 0, 4'b0001, 1, 0);
    step(1, 0, 4'b1001, 1, 3);
    step(1, 0, 4'b1001, 1, 0);
    saved = IN_DATA[31:0];
    step(1, 0, 4'h0, 1, -1);
    step(1, 0, 4'h0, 1, -1);
    chk("drain_out_valid", 32'(OUT_VALID), 32'd0);
    chk("drain_hold_data", OUT_DATA, saved);
    chk("drain_hold_ch", 32'(OUT_CH), 32'd0);
    step(1, 0, 4'b0100, 1, 2);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    OUT_READY = 1'b0;
    IN_VALID = 4'hF;
    q.delete();
    @(posedge CLK);
    #1;
`ifdef MUX_RR_PIPE_CNT_EN
    tb_cnt = '0;
    chk("rst2_xfer_cnt", 32'(XFER_CNT), 32'h0);
`endif
    chk("rst2_in_ready", 32'(IN_READY), 32'h0);
    chk("rst2_out_valid", 32'(OUT_VALID), 32'h0);
    chk("rst2_out_data", OUT_DATA, 32'h0);
    chk("rst2_out_ch", 32'(OUT_CH), 32'h0);
    IN_VALID = 4'h0;
    RST = 1'b0;
    step(1, 0, 4'hF, 1, 0);
    step(1, 0, 4'hF, 1, 1);
    step(1, 0, 4'h0, 1, -1);
    step(1, 0, 4'h0, 1, -1);
    @(posedge CLK);
    #3;
    chk("queue_empty", 32'(q.size()), 32'd0);
`ifdef MUX_RR_PIPE_CNT_EN
    chk("xfer_cnt", 32'(XFER_CNT), 32'(tb_cnt));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
